// File: rtl/param_updown_counter.sv
// Modulo-MOD up/down counter with synchronous clear, clamped parallel load,
// count enable, wrap/saturate boundary handling and wrap/overflow status.
module param_updown_counter #(
  parameter int unsigned      WIDTH = 4,
  parameter longint unsigned  MOD   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MOD - 1);
  // One extra bit so MOD == 2**WIDTH never truncates the clamp limit.
  localparam logic [WIDTH:0]   MAX_WIDE = (WIDTH+1)'(MOD - 1);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_CNT,
    ACT_LOAD,
    ACT_CLR
  } act_e;

  act_e             act;
  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamped;

  always_comb begin
    if (clr)       act = ACT_CLR;
    else if (load) act = ACT_LOAD;
    else if (en)   act = ACT_CNT;
    else           act = ACT_HOLD;
  end

  assign at_bound     = up_dn ? (out_q == MAX_C) : (out_q == '0);
  assign load_clamped = ({1'b0, load_val} > MAX_WIDE) ? MAX_C : load_val;

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    case (act)
      ACT_CLR: begin
        out_d = '0;
        ovf_d = 1'b0;
      end
      ACT_LOAD: out_d = load_clamped;
      ACT_CNT: begin
        if (at_bound) begin
          wrap_d = 1'b1;
          ovf_d  = 1'b1;
          if (!sat_mode) out_d = up_dn ? '0 : MAX_C;
        end else begin
          out_d = up_dn ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out  = out_q;
  assign tc   = at_bound;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's free-running 4-bit counter. It is a modulo-N up/down counter with synchronous clear, parallel load, count enable, and selectable wrap or saturate mode. It also provides terminal-count, wrap-pulse and sticky overflow status. It serves as the general-purpose event/timer counter for downstream control blocks.

Parameters:
WIDTH, 4, counter width in bits (1..32)
MOD, 16, count modulus; legal range 2..2**WIDTH; counter spans 0..MOD-1

Ports:
clk  input  1  system clock, rising-edge
rstn  input  1  asynchronous active-low reset
en  input  1  count enable; one step per cycle when high
up_dn  input  1  direction: 1 = count up, 0 = count down
clr  input  1  synchronous clear to 0
load  input  1  synchronous parallel load
load_val  input  WIDTH  value loaded when load=1
sat_mode  input  1  0 = wrap at boundary, 1 = saturate (hold) at boundary
out  output  WIDTH  current count, registered
tc  output  1  terminal count, combinational from out and up_dn
wrap  output  1  registered one-cycle pulse on boundary event
ovf  output  1  sticky boundary-event flag

Behaviour:
- Interface: one clock, clk; reset rstn is asynchronous, active-low.
- Reset (rstn=0, immediate, no clock needed): out=0, wrap=0, ovf=0. On release, counting resumes on the first rising edge with rstn=1.
- Per-edge priority: clr > load > en > hold.
- clr=1: out<=0, ovf<=0, wrap<=0. en, load and load_val are ignored.
- load=1 (clr=0):
  - out<=load_val when load_val<=MOD-1; otherwise out<=MOD-1 (clamped).
  - wrap<=0; ovf unchanged.
  - A load in the same cycle as en does not count.
- en=1, up_dn=1:
  - out<MOD-1: out<=out+1.
  - out==MOD-1, sat_mode=0: out<=0, wrap<=1, ovf<=1.
  - out==MOD-1, sat_mode=1: out holds MOD-1, wrap<=1, ovf<=1.
- en=1, up_dn=0:
  - out>0: out<=out-1.
  - out==0, sat_mode=0: out<=MOD-1, wrap<=1, ovf<=1.
  - out==0, sat_mode=1: out holds 0, wrap<=1, ovf<=1.
- en=0: out holds; wrap<=0.
- wrap: high for exactly one cycle, the cycle after the boundary edge. It stays high on consecutive cycles only if a boundary event occurs on each of those edges (e.g. saturated with en held high).
- tc = (up_dn & out==MOD-1) | (~up_dn & out==0). Combinational, independent of en and sat_mode.
- ovf: set by any boundary event. Cleared only by clr or reset.
- Direction changes mid-count take effect on the same edge; there is no extra latency.
- Arithmetic:
  - Comparisons use WIDTH bits and never overflow internally.
  - When MOD==2**WIDTH, out wraps naturally.
  - The load clamp compares at WIDTH+1 bits so MOD=2**WIDTH is handled.
- sat_mode is sampled each edge. Changing it has no effect until the next boundary.
- Reset asserted mid-count: outputs go to 0 asynchronously and the previous state is lost.

Test Plan:
- WIDTH=4, MOD=10; reset 20 ns then en=1, up_dn=1, sat_mode=0 -> out 0,1,...,9,0. wrap high one cycle after 9->0; ovf=1 thereafter; tc=1 while out=9.
- MOD=10, sat_mode=1, up_dn=1, en held 15 cycles -> out stops at 9. wrap high every cycle after reaching 9; out never exceeds 9.
- Down count from load_val=3, sat_mode=0 -> out 3,2,1,0,9,8. wrap pulses once after 0->9; tc=1 at out=0.
- load_val=12 with MOD=10 -> out=9. Then clr and load together -> out=0, ovf=0. Then load and en together with load_val=5 -> out=5, no increment.
- WIDTH=4, MOD=16, up count to 15 -> wraps to 0 natively, wrap pulse. Then toggle up_dn at out=0 -> next out=15, wrap=1.
- Assert rstn=0 asynchronously mid-cycle at out=6 with ovf=1 -> out, wrap and ovf go to 0 before the next clk edge. Release resumes from 0.
